wdt_ctrl: RTL and testbench

Register-mapped controller that sequences the watchdog timer's WDEN/WDLIVE/WTOCNT inputs from a simple valid/ready request bus. It turns software writes into correctly timed watchdog operations: enable, kick pulse and safe timeout reload. It also latches the watchdog's WTO output into a sticky status bit with an optional interrupt. It sits between the CPU-side peripheral bus and the watchdog, in the watchdog's clock domain.

---
 rtl/wdt_ctrl.sv | 166 ++++++++++++++++
 tb/tb_wdt_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wdt_ctrl.sv
// Register-mapped sequencer for the watchdog timer's WDEN/WDLIVE/WTOCNT inputs.
// Turns bus writes into timed enable, kick and safe-reload operations and latches WTO as sticky status.
module wdt_ctrl #(
    parameter int LIVE_CYCLES = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [3:0]       req_addr,
    input  logic [31:0]      req_wdata,
    output logic             rsp_valid,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    output logic             WDEN,
    output logic             WDLIVE,
    output logic [CNT_W-1:0] WTOCNT,
    input  logic             WTO,
    output logic             irq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_KICK,
        S_RL_OFF,
        S_RL_LOAD
    } state_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_KICK   = 2'd1;
    localparam logic [1:0] REG_CNT    = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam logic [7:0] LIVE_INIT = 8'(LIVE_CYCLES - 1);

    state_t           state, state_nx;
    logic             en, en_nx;
    logic             ie, ie_nx;
    logic             to, to_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] reload, reload_nx;
    logic [7:0]       live, live_nx;
    logic             rsp_valid_nx;
    logic             rsp_err_nx;
    logic [31:0]      rsp_rdata_nx;

    logic             accept;
    logic             addr_ok;
    logic [31:0]      cnt_ext;

    assign accept  = req_valid && (state == S_IDLE);
    assign addr_ok = (req_addr[1:0] == 2'b00);
    assign cnt_ext = 32'(cnt);

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_nx     = state;
        en_nx        = en;
        ie_nx        = ie;
        to_nx        = to;
        cnt_nx       = cnt;
        reload_nx    = reload;
        live_nx      = live;
        rsp_valid_nx = accept;
        rsp_err_nx   = accept && !addr_ok;
        rsp_rdata_nx = '0;

        case (state)
            S_IDLE: begin
                if (accept && addr_ok) begin
                    case (req_addr[3:2])
                        REG_CTRL: begin
                            if (req_write) begin
                                en_nx = req_wdata[0];
                                ie_nx = req_wdata[1];
                            end else begin
                                rsp_rdata_nx = {30'd0, ie, en};
                            end
                        end
                        REG_KICK: begin
                            if (req_write) begin
                                state_nx = S_KICK;
                                live_nx  = LIVE_INIT;
                            end
                        end
                        REG_CNT: begin
                            if (req_write) begin
                                // A running watchdog is disabled around the count change so it never sees WTOCNT move.
                                if (en) begin
                                    state_nx  = S_RL_OFF;
                                    reload_nx = req_wdata[CNT_W-1:0];
                                end else begin
                                    cnt_nx = req_wdata[CNT_W-1:0];
                                end
                            end else begin
                                rsp_rdata_nx = cnt_ext;
                            end
                        end
                        default: begin
                            if (req_write) begin
                                if (req_wdata[0]) to_nx = 1'b0;
                            end else begin
                                rsp_rdata_nx = {30'd0, (state != S_IDLE), to};
                            end
                        end
                    endcase
                end
            end
            S_KICK: begin
                if (live == 8'd0) state_nx = S_IDLE;
                else              live_nx  = live - 8'd1;
            end
            S_RL_OFF: begin
                state_nx = S_RL_LOAD;
                cnt_nx   = reload;
            end
            S_RL_LOAD: state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase

        // A timeout in the same cycle as a clear must win.
        if (WTO) to_nx = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en        <= 1'b0;
            ie        <= 1'b0;
            to        <= 1'b0;
            cnt       <= '0;
            reload    <= '0;
            live      <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            en        <= en_nx;
            ie        <= ie_nx;
            to        <= to_nx;
            cnt       <= cnt_nx;
            reload    <= reload_nx;
            live      <= live_nx;
            rsp_valid <= rsp_valid_nx;
            rsp_err   <= rsp_err_nx;
            rsp_rdata <= rsp_rdata_nx;
        end
    end

    assign req_ready = (state == S_IDLE);
    assign WDEN      = en && ((state == S_IDLE) || (state == S_KICK));
    assign WDLIVE    = (state != S_IDLE);
    assign WTOCNT    = cnt;
    assign irq       = to && ie;

endmodule

// File: tb/tb_wdt_ctrl.sv
// Self-checking bench for wdt_ctrl: directed scenarios plus randomized transactions
// checked against a register-level reference model.
module tb_wdt_ctrl;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [3:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        WDEN;
    logic        WDLIVE;
    logic [31:0] WTOCNT;
    logic        WTO = 1'b0;
    logic        irq;

    int checks = 0;
    int failures = 0;

    wdt_ctrl #(.LIVE_CYCLES(L), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .WDEN(WDEN), .WDLIVE(WDLIVE), .WTOCNT(WTOCNT), .WTO(WTO), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds a request until accepted; returns in the cycle after acceptance with the response.
    task automatic bus(input logic w, input logic [3:0] a, input logic [31:0] d,
                       output int waits, output logic rv, output logic [31:0] rd, output logic er);
        waits = 0;
        rv = 1'b0; rd = '0; er = 1'b0;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        while (!req_ready && waits < 64) begin
            step();
            waits++;
        end
        if (!req_ready) begin
            checks++; failures++;
            $display("FAIL bus_timeout addr=%h waited=%0d", a, waits);
            req_valid = 1'b0;
            return;
        end
        step();
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rv = rsp_valid; rd = rsp_rdata; er = rsp_err;
    endtask

    task automatic test_reset();
        int w; logic rv, er; logic [31:0] rd;
        logic [3:0] addrs [3] = '{4'h0, 4'h8, 4'hC};
        rst = 1'b1;
        step(); step();
        checks++;
        if ({req_ready, WDEN, WDLIVE, irq, rsp_valid} !== 5'b10000) begin
            failures++; $display("FAIL rst_outputs got=%b exp=10000", {req_ready, WDEN, WDLIVE, irq, rsp_valid});
        end
        checks++;
        if (WTOCNT !== 32'd0) begin failures++; $display("FAIL rst_wtocnt got=%h exp=0", WTOCNT); end
        rst = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            bus(1'b0, addrs[i], 32'd0, w, rv, rd, er);
            checks++;
            if ({rv, er, rd} !== {1'b1, 1'b0, 32'd0}) begin
                failures++; $display("FAIL rst_read a=%h got v=%b e=%b d=%h exp v=1 e=0 d=0", addrs[i], rv, er, rd);
            end
            step();
            checks++;
            if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rsp_one_cycle got=%b exp=0", rsp_valid); end
        end
    endtask

    task automatic test_ctrl_cnt();
        int w; logic rv, er; logic [31:0] rd;
        bus(1'b1, 4'h8, 32'd100, w, rv, rd, er);
        checks++;
        if ({WTOCNT, req_ready, WDEN} !== {32'd100, 1'b1, 1'b0}) begin
            failures++; $display("FAIL cnt_write_idle got cnt=%0d rdy=%b en=%b exp 100 1 0", WTOCNT, req_ready, WDEN);
        end
        bus(1'b1, 4'h0, 32'h3, w, rv, rd, er);
        checks++;
        if (WDEN !== 1'b1) begin failures++; $display("FAIL ctrl_wden got=%b exp=1", WDEN); end
        bus(1'b0, 4'h0, 32'd0, w, rv, rd, er);
        checks++;
        if (rd !== 32'h3) begin failures++; $display("FAIL ctrl_readback got=%h exp=3", rd); end
    endtask

    task automatic test_kick();
        int w; logic rv, er; logic [31:0] rd;
        bus(1'b1, 4'h4, 32'd0, w, rv, rd, er);
        for (int i = 0; i < L; i++) begin
            checks++;
            if ({WDLIVE, req_ready, WDEN} !== 3'b101) begin
                failures++; $display("FAIL kick_cycle%0d got=%b exp=101", i, {WDLIVE, req_ready, WDEN});
            end
            step();
        end
        checks++;
        if ({WDLIVE, req_ready} !== 2'b01) begin
            failures++; $display("FAIL kick_end got=%b exp=01", {WDLIVE, req_ready});
        end
        bus(1'b1, 4'h4, 32'd0, w, rv, rd, er);
        bus(1'b0, 4'h0, 32'd0, w, rv, rd, er);
        checks++;
        if ({w, rd} !== {L, 32'h3}) begin
            failures++; $display("FAIL kick_held_req got waits=%0d d=%h exp waits=%0d d=3", w, rd, L);
        end
    endtask

    task automatic test_reload();
        int w; logic rv, er; logic [31:0] rd;
        bus(1'b1, 4'h8, 32'd50, w, rv, rd, er);
        checks++;
        if ({WDEN, WDLIVE, req_ready, WTOCNT} !== {3'b010, 32'd100}) begin
            failures++; $display("FAIL reload_t1 got=%b cnt=%0d exp=010 cnt=100", {WDEN, WDLIVE, req_ready}, WTOCNT);
        end
        step();
        checks++;
        if ({WDEN, WDLIVE, req_ready, WTOCNT} !== {3'b010, 32'd50}) begin
            failures++; $display("FAIL reload_t2 got=%b cnt=%0d exp=010 cnt=50", {WDEN, WDLIVE, req_ready}, WTOCNT);
        end
        step();
        checks++;
        if ({WDEN, WDLIVE, req_ready, WTOCNT} !== {3'b101, 32'd50}) begin
            failures++; $display("FAIL reload_t3 got=%b cnt=%0d exp=101 cnt=50", {WDEN, WDLIVE, req_ready}, WTOCNT);
        end
    endtask

    task automatic test_wto();
        int w; logic rv, er; logic [31:0] rd;
        WTO = 1'b1; step(); WTO = 1'b0;
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL wto_irq got=%b exp=1", irq); end
        bus(1'b0, 4'hC, 32'd0, w, rv, rd, er);
        checks++;
        if (rd !== 32'd1) begin failures++; $display("FAIL wto_status got=%h exp=1", rd); end
        bus(1'b1, 4'hC, 32'd1, w, rv, rd, er);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL w1c_irq got=%b exp=0", irq); end
        bus(1'b0, 4'hC, 32'd0, w, rv, rd, er);
        checks++;
        if (rd !== 32'd0) begin failures++; $display("FAIL w1c_status got=%h exp=0", rd); end
        WTO = 1'b1;
        bus(1'b1, 4'hC, 32'd1, w, rv, rd, er);
        WTO = 1'b0;
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL set_wins_irq got=%b exp=1", irq); end
        bus(1'b1, 4'h0, 32'd1, w, rv, rd, er);
        checks++;
        if ({irq, WDEN} !== 2'b01) begin failures++; $display("FAIL ie_mask got=%b exp=01", {irq, WDEN}); end
        bus(1'b0, 4'hC, 32'd0, w, rv, rd, er);
        checks++;
        if (rd !== 32'd1) begin failures++; $display("FAIL mask_keeps_to got=%h exp=1", rd); end
        bus(1'b1, 4'hC, 32'd1, w, rv, rd, er);
    endtask

    task automatic test_errors();
        int w; logic rv, er; logic [31:0] rd;
        logic [3:0]  ea [4] = '{4'h5, 4'h6, 4'hD, 4'h9};
        logic        ew [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            bus(ew[i], ea[i], 32'hFFFF_FFFF, w, rv, rd, er);
            checks++;
            if ({rv, er, rd} !== {2'b11, 32'd0}) begin
                failures++; $display("FAIL err_a%h got v=%b e=%b d=%h exp v=1 e=1 d=0", ea[i], rv, er, rd);
            end
        end
        checks++;
        if ({req_ready, WDLIVE, WTOCNT} !== {2'b10, 32'd50}) begin
            failures++; $display("FAIL err_no_effect got=%b cnt=%0d exp=10 cnt=50", {req_ready, WDLIVE}, WTOCNT);
        end
        bus(1'b0, 4'h0, 32'd0, w, rv, rd, er);
        checks++;
        if ({er, rd} !== {1'b0, 32'd1}) begin failures++; $display("FAIL err_ctrl_kept got e=%b d=%h exp e=0 d=1", er, rd); end
        bus(1'b0, 4'h4, 32'd0, w, rv, rd, er);
        checks++;
        if ({er, rd} !== {1'b0, 32'd0}) begin failures++; $display("FAIL kick_reads0 got e=%b d=%h exp e=0 d=0", er, rd); end
    endtask

    task automatic test_rst_mid_kick();
        int w; logic rv, er; logic [31:0] rd;
        bus(1'b1, 4'h4, 32'd0, w, rv, rd, er);
        step();
        rst = 1'b1;
        #1;
        checks++;
        if ({WDLIVE, WDEN, req_ready, irq, WTOCNT} !== {4'b0010, 32'd0}) begin
            failures++; $display("FAIL rst_mid_kick got=%b cnt=%0d exp=0010 cnt=0", {WDLIVE, WDEN, req_ready, irq}, WTOCNT);
        end
        step();
        rst = 1'b0;
        bus(1'b0, 4'h0, 32'd0, w, rv, rd, er);
        checks++;
        if (rd !== 32'd0) begin failures++; $display("FAIL rst_ctrl_cleared got=%h exp=0", rd); end
    endtask

    task automatic test_random();
        int w, busy, exp_busy;
        logic rv, er, wr, wto, exp_err;
        logic [3:0]  a;
        logic [31:0] d, rd, exp_rd, prev_cnt;
        logic m_en, m_ie, m_to;
        logic [31:0] m_cnt;
        rst = 1'b1; step(); rst = 1'b0; step();
        m_en = 0; m_ie = 0; m_to = 0; m_cnt = '0;
        for (int n = 0; n < 300; n++) begin
            wr  = 1'($urandom_range(0, 1));
            a   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            d   = $urandom;
            wto = ($urandom_range(0, 5) == 0);
            exp_err = (a[1:0] != 2'b00);
            exp_rd = '0;
            exp_busy = 0;
            if (!exp_err && !wr) begin
                if (a == 4'h0) exp_rd = {30'd0, m_ie, m_en};
                if (a == 4'h8) exp_rd = m_cnt;
                if (a == 4'hC) exp_rd = {31'd0, m_to};
            end
            if (!exp_err && wr) begin
                if (a == 4'h0) begin m_en = d[0]; m_ie = d[1]; end
                if (a == 4'h4) exp_busy = L;
                if (a == 4'h8) begin exp_busy = m_en ? 2 : 0; m_cnt = d; end
                if (a == 4'hC && d[0]) m_to = 1'b0;
            end
            if (wto) m_to = 1'b1;
            WTO = wto;
            bus(wr, a, d, w, rv, rd, er);
            WTO = 1'b0;
            checks++;
            if ({rv, er, rd} !== {1'b1, exp_err, exp_rd}) begin
                failures++; $display("FAIL rnd_rsp n=%0d a=%h w=%b got e=%b d=%h exp e=%b d=%h", n, a, wr, er, rd, exp_err, exp_rd);
            end
            busy = 0;
            prev_cnt = WTOCNT;
            while (!req_ready && busy < 64) begin
                if (WDEN) begin
                    checks++;
                    if (WTOCNT !== prev_cnt) begin
                        failures++; $display("FAIL rnd_cnt_while_en n=%0d got=%h exp=%h", n, WTOCNT, prev_cnt);
                    end
                end
                prev_cnt = WTOCNT;
                step();
                busy++;
            end
            checks++;
            if ({busy, WDEN, irq, WTOCNT} !== {exp_busy, m_en, m_to & m_ie, m_cnt}) begin
                failures++; $display("FAIL rnd_state n=%0d got busy=%0d en=%b irq=%b cnt=%h exp busy=%0d en=%b irq=%b cnt=%h",
                                     n, busy, WDEN, irq, WTOCNT, exp_busy, m_en, m_to & m_ie, m_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ctrl_cnt();
        test_kick();
        test_reload();
        test_wto();
        test_errors();
        test_rst_mid_kick();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
